mem_wb_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline register, directly upstream of the writeback unit.
- Accepts one instruction per cycle from EX/MEM and performs the data-memory load or store through a req/ack handshake.
- Formats load data (byte/half/word, sign/zero extension) and registers wb_src, rd, result, load data and CSR data for writeback.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_wb_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register.
// Holds one load/store across a req/ack handshake and formats load data.
module mem_wb_stage #(
  parameter int XLEN          = 32,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      in_mem_op,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_wb_src,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [XLEN-1:0] in_csr_dataout,
  input  logic            flush,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [2:0]      wb_src,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] dmem_dataout,
  output logic [XLEN-1:0] csr_dataout,
  output logic            misalign
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e state_q, state_d;

  logic [2:0]      hf3_q, hwb_q;
  logic [1:0]      hoff_q;
  logic            hwe_q;
  logic [4:0]      hrd_q;
  logic [XLEN-1:0] hres_q, hsd_q, hcsr_q;

  logic [2:0]      wb_q, wb_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic [XLEN-1:0] csr_q, csr_d;
  logic            mis_q, mis_d;

  logic            accept, is_mem, mis, trap, go;
  logic [XLEN-1:0] sh, fmt;

  assign accept = (state_q == IDLE) && in_valid && !flush;
  assign is_mem = accept &&
                  (in_mem_op == 2'b01 || in_mem_op == 2'b10);
  // size from funct3[1:0]: 00 byte, 01 half, else word
  assign mis    = (in_funct3[1:0] == 2'b01 && in_result[0]) ||
                  (in_funct3[1] && in_result[1:0] != 2'b00);
  assign trap   = is_mem && mis && MISALIGN_TRAP;
  assign go     = is_mem && !trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go)       state_d = REQ;
      REQ:  if (dmem_ack) state_d = IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wstrb = 4'b0000;
    dmem_wdata = '0;
    if (state_q == REQ) begin
      stall     = 1'b1;
      dmem_req  = 1'b1;
      dmem_we   = hwe_q;
      dmem_addr = {hres_q[XLEN-1:2], 2'b00};
      if (hwe_q) begin
        unique case (1'b1)
          hf3_q[1:0] == 2'b00: begin
            dmem_wstrb = 4'b0001 << hoff_q;
            dmem_wdata = {4{hsd_q[7:0]}};
          end
          hf3_q[1:0] == 2'b01: begin
            dmem_wstrb = 4'b0011 << hoff_q;
            dmem_wdata = {2{hsd_q[15:0]}};
          end
          default: begin
            dmem_wstrb = 4'b1111;
            dmem_wdata = hsd_q;
          end
        endcase
      end
    end
  end

  assign sh = dmem_rdata >> {hoff_q, 3'b000};

  always_comb begin
    unique case (hf3_q)
      3'b000:  fmt = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  fmt = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  fmt = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  fmt = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: fmt = dmem_rdata;
    endcase
  end

  // hold register; without trapping, a misaligned offset is forced to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hf3_q  <= '0;
      hwb_q  <= '0;
      hoff_q <= '0;
      hwe_q  <= 1'b0;
      hrd_q  <= '0;
      hres_q <= '0;
      hsd_q  <= '0;
      hcsr_q <= '0;
    end else if (go) begin
      hf3_q  <= in_funct3;
      hwb_q  <= in_wb_src;
      hoff_q <= mis ? 2'b00 : in_result[1:0];
      hwe_q  <= in_mem_op[1];
      hrd_q  <= in_rd;
      hres_q <= in_result;
      hsd_q  <= in_store_data;
      hcsr_q <= in_csr_dataout;
    end
  end

  always_comb begin
    wb_d  = wb_q;
    rd_d  = rd_q;
    res_d = res_q;
    ld_d  = ld_q;
    csr_d = csr_q;
    mis_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept && !is_mem) begin
        wb_d  = in_wb_src;
        rd_d  = in_rd;
        res_d = in_result;
        csr_d = in_csr_dataout;
      end else begin
        wb_d  = 3'b000;
        mis_d = trap;
      end
    end else if (dmem_ack) begin
      wb_d  = hwb_q;
      rd_d  = hrd_q;
      res_d = hres_q;
      ld_d  = fmt;
      csr_d = hcsr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
      ld_q  <= '0;
      csr_q <= '0;
      mis_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      rd_q  <= rd_d;
      res_q <= res_d;
      ld_q  <= ld_d;
      csr_q <= csr_d;
      mis_q <= mis_d;
    end
  end

  assign wb_src       = wb_q;
  assign rd           = rd_q;
  assign result       = res_q;
  assign dmem_dataout = ld_q;
  assign csr_dataout  = csr_q;
  assign misalign     = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_mem_op;
  logic [2:0]  in_funct3;
  logic [2:0]  in_wb_src;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [31:0] in_csr_dataout;
  logic        flush;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [2:0]  wb_src;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] dmem_dataout;
  logic [31:0] csr_dataout;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_mem_op(in_mem_op),
    .in_funct3(in_funct3), .in_wb_src(in_wb_src),
    .in_rd(in_rd), .in_result(in_result),
    .in_store_data(in_store_data),
    .in_csr_dataout(in_csr_dataout),
    .flush(flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_src(wb_src),
    .rd(rd), .result(result),
    .dmem_dataout(dmem_dataout),
    .csr_dataout(csr_dataout), .misalign(misalign)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [2:0] wb, input logic [4:0] r);
    in_valid      = 1'b1;
    in_mem_op     = op;
    in_funct3     = f3;
    in_result     = addr;
    in_store_data = sd;
    in_wb_src     = wb;
    in_rd         = r;
  endtask

  task automatic load_imm(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr,
                          input logic [31:0] rdat,
                          input logic [31:0] exp);
    issue(2'b01, f3, addr, 32'h0, 3'b110, 5'd3);
    tick();
    in_valid   = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = rdat;
    tick();
    dmem_ack   = 1'b0;
    chk(tag, dmem_dataout, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mem_op = 2'b00;
    in_funct3 = 3'b000; in_wb_src = 3'b000; in_rd = 5'd0;
    in_result = 32'h0; in_store_data = 32'h0;
    in_csr_dataout = 32'h0; flush = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_wstrb", {28'b0, dmem_wstrb}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wb", {29'b0, wb_src}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_dataout", dmem_dataout, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    rst_n = 1'b1;

    // non-memory op, latency 1
    issue(2'b00, 3'b000, 32'h1234, 32'h0, 3'b101, 5'd5);
    in_csr_dataout = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("alu_result", result, 32'h1234);
    chk("alu_rd", {27'b0, rd}, 32'd5);
    chk("alu_wb", {29'b0, wb_src}, 32'h5);
    chk("alu_csr", csr_dataout, 32'h55);
    chk("alu_stall", {31'b0, stall}, 32'h0);

    // LB 0x103 with immediate ack
    issue(2'b01, 3'b000, 32'h103, 32'h0, 3'b110, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("lb_stall", {31'b0, stall}, 32'h1);
    chk("lb_req", {31'b0, dmem_req}, 32'h1);
    chk("lb_we", {31'b0, dmem_we}, 32'h0);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_wstrb", {28'b0, dmem_wstrb}, 32'h0);
    chk("lb_bubble", {31'b0, wb_src[2]}, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_ack = 1'b0;
    chk("lb_stall_end", {31'b0, stall}, 32'h0);
    chk("lb_data", dmem_dataout, 32'hFFFF_FF80);
    chk("lb_wb", {29'b0, wb_src}, 32'h6);
    chk("lb_rd", {27'b0, rd}, 32'd7);
    chk("lb_result", result, 32'h103);

    // LH 0x102, ack delayed 3 cycles, flush during REQ ignored
    issue(2'b01, 3'b001, 32'h102, 32'h0, 3'b110, 5'd9);
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall) n++;
      chk("lh_addr", dmem_addr, 32'h100);
      if (i == 1) flush = 1'b1;
      if (i == 3) begin
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
      end
      tick();
    end
    dmem_ack = 1'b0; flush = 1'b0;
    chk("lh_stall_cycles", n, 32'd4);
    chk("lh_stall_end", {31'b0, stall}, 32'h0);
    chk("lh_data", dmem_dataout, 32'hFFFF_8001);
    chk("lh_rd", {27'b0, rd}, 32'd9);

    // SH 0x102, held two cycles before ack
    issue(2'b10, 3'b001, 32'h102, 32'hAAAA_BEEF, 3'b001, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", {31'b0, dmem_req}, 32'h1);
      chk("sh_we", {31'b0, dmem_we}, 32'h1);
      chk("sh_addr", dmem_addr, 32'h100);
      chk("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      chk("sh_bubble", {31'b0, wb_src[2]}, 32'h0);
      if (i == 2) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    chk("sh_wb", {29'b0, wb_src}, 32'h1);
    chk("sh_req_end", {31'b0, dmem_req}, 32'h0);

    // SB 0x001 and SW 0x008
    issue(2'b10, 3'b000, 32'h001, 32'h1234_5678, 3'b000, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("sb_wstrb", {28'b0, dmem_wstrb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h7878_7878);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    issue(2'b10, 3'b010, 32'h008, 32'hCAFE_F00D, 3'b000, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("sw_wstrb", {28'b0, dmem_wstrb}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    chk("sw_addr", dmem_addr, 32'h008);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;

    load_imm("lhu_data", 3'b101, 32'h102, 32'h8001_1234, 32'h0000_8001);
    load_imm("lbu_data", 3'b100, 32'h101, 32'h0000_80FF, 32'h0000_0080);
    load_imm("lb0_data", 3'b000, 32'h100, 32'h1234_5678, 32'h0000_0078);
    load_imm("lw_data", 3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // misaligned LW
    issue(2'b01, 3'b010, 32'h101, 32'h0, 3'b110, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("mis_req", {31'b0, dmem_req}, 32'h0);
    chk("mis_stall", {31'b0, stall}, 32'h0);
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_bubble", {31'b0, wb_src[2]}, 32'h0);
    tick();
    chk("mis_pulse_end", {31'b0, misalign}, 32'h0);

    // flush in IDLE
    issue(2'b00, 3'b000, 32'h77, 32'h0, 3'b101, 5'd6);
    flush = 1'b1;
    tick();
    chk("flush_alu_wb", {29'b0, wb_src}, 32'h0);
    issue(2'b01, 3'b010, 32'h200, 32'h0, 3'b110, 5'd6);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_ld_req", {31'b0, dmem_req}, 32'h0);
    chk("flush_ld_stall", {31'b0, stall}, 32'h0);

    // reset during REQ
    issue(2'b01, 3'b010, 32'h200, 32'h0, 3'b110, 5'd8);
    tick();
    in_valid = 1'b0;
    chk("rreq_req", {31'b0, dmem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rreq_req_drop", {31'b0, dmem_req}, 32'h0);
    chk("rreq_stall_drop", {31'b0, stall}, 32'h0);
    tick();
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    tick();
    dmem_ack = 1'b0;
    chk("rreq_idle_req", {31'b0, dmem_req}, 32'h0);
    chk("rreq_wb", {29'b0, wb_src}, 32'h0);
    chk("rreq_data", dmem_dataout, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
